// File: rtl/rvb_mcu_issue_pkg.sv
// Shared definitions for the bit-manipulation issue path: instruction field
// positions, the destination-register type and the decoded op-select bits.
package rvb_mcu_issue_pkg;

  localparam int RVB_INSN_RD_LSB = 7;
  localparam int RVB_INSN_RD_W   = 5;
  localparam int RVB_INSN_B3     = 3;
  localparam int RVB_INSN_B13    = 13;
  localparam int RVB_INSN_B14    = 14;

  typedef logic [RVB_INSN_RD_W-1:0] rd_idx_t;

  typedef struct packed {
    logic insn14;
    logic insn13;
    logic insn3;
  } op_sel_t;

  function automatic rd_idx_t insn_rd(input logic [31:0] insn);
    return insn[RVB_INSN_RD_LSB +: RVB_INSN_RD_W];
  endfunction

endpackage

// File: rtl/rvb_mcu_issue_tagfifo.sv
// Circular FIFO of destination-register tags for ops in flight in the unit.
// Occupancy is tracked separately so full and empty are unambiguous.
module rvb_mcu_issue_tagfifo
  import rvb_mcu_issue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clock,
  input  logic    resetn,
  input  logic    push,
  input  rd_idx_t push_tag,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output rd_idx_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  rd_idx_t         mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [OW-1:0]   occ;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_tag;
  end

  assign full  = (occ == OW'(DEPTH));
  assign empty = (occ == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/rvb_mcu_issue.sv
// CPU-side initiator for the multi-cycle bit-manipulation units: registers ops
// towards the unit, tags them with rd, and returns {rd, result} for writeback.
module rvb_mcu_issue
  import rvb_mcu_issue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_insn,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  output logic            din_valid,
  input  logic            din_ready,
  output logic [XLEN-1:0] din_rs1,
  output logic [XLEN-1:0] din_rs2,
  output logic            din_insn3,
  output logic            din_insn13,
  output logic            din_insn14,
  input  logic            dout_valid,
  output logic            dout_ready,
  input  logic [XLEN-1:0] dout_rd,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd_idx,
  output logic [XLEN-1:0] wb_data,
  output logic            busy,
  output logic            err
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("rvb_mcu_issue: XLEN must be 32 or 64");
  end
  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("rvb_mcu_issue: DEPTH must be 1..8");
  end

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] cnt;
  logic          req_fire;
  logic          dout_fire;
  logic          wb_fire;
  logic          tag_pop;
  logic          tag_full;
  logic          tag_empty;
  rd_idx_t       tag_head;
  op_sel_t       req_sel;

  // Ready terms are gated by resetn so every output reads 0 while in reset.
  assign req_ready  = resetn && (!din_valid || din_ready) && (cnt < CW'(DEPTH)) && !tag_full;
  assign dout_ready = resetn && (tag_empty || !wb_valid || wb_ready);
  assign busy       = din_valid || (cnt != '0);

  assign req_fire  = req_valid && req_ready;
  assign dout_fire = dout_valid && dout_ready;
  assign wb_fire   = wb_valid && wb_ready;
  assign tag_pop   = dout_fire && !tag_empty;

  assign req_sel.insn14 = req_insn[RVB_INSN_B14];
  assign req_sel.insn13 = req_insn[RVB_INSN_B13];
  assign req_sel.insn3  = (XLEN == 64) ? req_insn[RVB_INSN_B3] : 1'b0;

  rvb_mcu_issue_tagfifo #(.DEPTH(DEPTH)) u_tagfifo (
    .clock    (clock),
    .resetn   (resetn),
    .push     (req_fire),
    .push_tag (insn_rd(req_insn)),
    .pop      (tag_pop),
    .full     (tag_full),
    .empty    (tag_empty),
    .head     (tag_head)
  );

  // Issue register: payload only loads on req fire, so it is stable while stalled.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      din_valid  <= 1'b0;
      din_rs1    <= '0;
      din_rs2    <= '0;
      din_insn3  <= 1'b0;
      din_insn13 <= 1'b0;
      din_insn14 <= 1'b0;
    end else if (req_fire) begin
      din_valid  <= 1'b1;
      din_rs1    <= req_rs1;
      din_rs2    <= req_rs2;
      din_insn3  <= req_sel.insn3;
      din_insn13 <= req_sel.insn13;
      din_insn14 <= req_sel.insn14;
    end else if (din_ready) begin
      din_valid  <= 1'b0;
    end
  end

  // A result with no pending tag is swallowed and flagged instead of written back.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wb_valid  <= 1'b0;
      wb_rd_idx <= '0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      if (tag_pop) begin
        wb_valid  <= 1'b1;
        wb_rd_idx <= tag_head;
        wb_data   <= dout_rd;
      end else if (wb_fire) begin
        wb_valid  <= 1'b0;
      end
      if (dout_fire && tag_empty) err <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else begin
      case ({req_fire, wb_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
